// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one operand bit per cycle, shift-add multiply
// and restoring divide on operand magnitudes, sign fix-up on the final cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             Flush,
    input  logic             InValid,
    output logic             InReady,
    input  logic [2:0]       MDControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Result,
    output logic             OutValid,
    input  logic             OutReady,
    output logic             N,
    output logic             Z,
    output logic             V,
    output logic             DZ
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [2*WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0]   oper_q, oper_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               neg_q, neg_d;
    logic               v_q, v_d;
    logic               dz_q, dz_d;

    logic               accept;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_cand, div_diff;
    logic [2*WIDTH-1:0] step;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem, fin;

    // Operand sign/magnitude decode, one iteration step and the final sign fix-up.
    always_comb begin
        accept = InValid && (state_q == IDLE) && !Flush;
        a_neg  = A[WIDTH-1] && ((MDControl == 3'b001) || (MDControl == 3'b010) ||
                                (MDControl == 3'b100) || (MDControl == 3'b110));
        b_neg  = B[WIDTH-1] && ((MDControl == 3'b001) || (MDControl == 3'b100) ||
                                (MDControl == 3'b110));
        a_mag  = a_neg ? -A : A;
        b_mag  = b_neg ? -B : B;

        mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, oper_q} : '0);
        div_cand = work_q[2*WIDTH-1:WIDTH-1];
        div_diff = div_cand - {1'b0, oper_q};
        if (op_q[2]) begin
            step = {(div_diff[WIDTH] ? div_cand[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                    work_q[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
            step = {mul_sum, work_q[WIDTH-1:1]};
        end

        prod = neg_q ? -step : step;
        quo  = step[WIDTH-1:0];
        rem  = step[2*WIDTH-1:WIDTH];
        case (op_q)
            3'b000:         fin = prod[WIDTH-1:0];
            3'b001, 3'b010,
            3'b011:         fin = prod[2*WIDTH-1:WIDTH];
            3'b100, 3'b101: fin = dz_q ? '1 : (neg_q ? -quo : quo);
            default:        fin = dz_q ? a_raw_q : (neg_q ? -rem : rem);
        endcase
    end

    // Next-state logic: accept in IDLE, iterate in CALC, hold in DONE; Flush wins.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        work_d   = work_q;
        oper_d   = oper_q;
        a_raw_d  = a_raw_q;
        result_d = result_q;
        neg_d    = neg_q;
        v_d      = v_q;
        dz_d     = dz_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CALC;
                    cnt_d   = CW'(WIDTH - 1);
                    op_d    = MDControl;
                    a_raw_d = A;
                    dz_d    = MDControl[2] && (B == '0);
                    v_d     = ((MDControl == 3'b100) || (MDControl == 3'b110)) &&
                              (A == MOST_NEG) && (B == '1);
                    if (MDControl[2]) begin
                        work_d = {{WIDTH{1'b0}}, a_mag};
                        oper_d = b_mag;
                        neg_d  = MDControl[1] ? a_neg : (a_neg ^ b_neg);
                    end else begin
                        work_d = {{WIDTH{1'b0}}, b_mag};
                        oper_d = a_mag;
                        neg_d  = a_neg ^ b_neg;
                    end
                end
            end
            CALC: begin
                work_d = step;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d  = DONE;
                    cnt_d    = '0;
                    result_d = fin;
                end
            end
            DONE: begin
                if (OutReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (Flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            work_q   <= '0;
            oper_q   <= '0;
            a_raw_q  <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
            v_q      <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            work_q   <= work_d;
            oper_q   <= oper_d;
            a_raw_q  <= a_raw_d;
            result_q <= result_d;
            neg_q    <= neg_d;
            v_q      <= v_d;
            dz_q     <= dz_d;
        end
    end

    // Handshake and flag outputs; flags only meaningful while OutValid.
    always_comb begin
        InReady  = (state_q == IDLE);
        OutValid = (state_q == DONE);
        Result   = result_q;
        N        = OutValid && result_q[WIDTH-1];
        Z        = OutValid && (result_q == '0);
        V        = OutValid && v_q;
        DZ       = OutValid && dz_q;
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed vectors, randomized ops against a plain
// arithmetic reference model, back-pressure, flush and reset abort sequences.
module tb_muldiv_unit;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset_n = 1'b1;
   logic          Flush = 1'b0;
   logic          InValid = 1'b0;
   logic          OutReady = 1'b0;
   logic [2:0]    MDControl = 3'd0;
   logic [W-1:0]  A = '0;
   logic [W-1:0]  B = '0;
   logic          InReady, OutValid, N, Z, V, DZ;
   logic [W-1:0]  Result;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         v;
      logic         dz;
   } vec_t;

   vec_t vecs [16];

   muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset_n(reset_n), .Flush(Flush), .InValid(InValid), .InReady(InReady),
      .MDControl(MDControl), .A(A), .B(B), .Result(Result), .OutValid(OutValid),
      .OutReady(OutReady), .N(N), .Z(Z), .V(V), .DZ(DZ)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Single comparison point: every check steps the counters used by the summary.
   task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference model from the arithmetic definition of each operation.
   function automatic void refModel(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] res, output logic v, output logic dz);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     p;
      int              qa, qb;
      v  = 1'b0;
      dz = 1'b0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      qa = $signed(a);
      qb = $signed(b);
      res = '0;
      case (op)
         3'd0: begin p = ua * ub; res = p[31:0]; end
         3'd1: begin p = sa * sb; res = p[63:32]; end
         3'd2: begin p = sa * longint'(ub); res = p[63:32]; end
         3'd3: begin p = ua * ub; res = p[63:32]; end
         3'd4, 3'd6: begin
            if (b == 0) begin
               dz  = 1'b1;
               res = (op == 3'd4) ? '1 : a;
            end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
               v   = 1'b1;
               res = (op == 3'd4) ? a : '0;
            end else begin
               res = (op == 3'd4) ? qa / qb : qa % qb;
            end
         end
         default: begin
            if (b == 0) begin
               dz  = 1'b1;
               res = (op == 3'd5) ? '1 : a;
            end else begin
               res = (op == 3'd5) ? a / b : a % b;
            end
         end
      endcase
   endfunction

   // Present an operation, pass the accept edge, return at the following negedge.
   task automatic startOp(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int waitCycles;
      @(negedge clk);
      InValid   = 1'b1;
      MDControl = op;
      A         = a;
      B         = b;
      waitCycles = 0;
      while (!InReady && waitCycles < 100) begin
         @(negedge clk);
         waitCycles++;
      end
      if (!InReady) checkVal("accept_timeout", 64'd1, 64'd0);
      @(posedge clk);
      @(negedge clk);
      InValid = 1'b0;
   endtask

   // Start an operation and wait (bounded) for OutValid; lat counts edges from the accept edge.
   task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output int lat);
      OutReady = 1'b0;
      startOp(op, a, b);
      lat = 1;
      while (!OutValid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      if (!OutValid) checkVal("outvalid_timeout", 64'd1, 64'd0);
   endtask

   // Compare Result and flags with expected values; N and Z follow from the result.
   task automatic checkOutput(input string name, input logic [W-1:0] res, input logic v, input logic dz);
      checkVal({name, "_res"}, 64'(Result), 64'(res));
      checkVal({name, "_N"}, 64'(N), 64'(res[W-1]));
      checkVal({name, "_Z"}, 64'(Z), 64'(res == '0));
      checkVal({name, "_V"}, 64'(V), 64'(v));
      checkVal({name, "_DZ"}, 64'(DZ), 64'(dz));
   endtask

   // Consume the result with a one-cycle OutReady pulse.
   task automatic releaseResult();
      OutReady = 1'b1;
      @(negedge clk);
      OutReady = 1'b0;
   endtask

   // Main sequence.
   initial begin
      int          lat;
      logic [W-1:0] eres;
      logic         ev, edz;
      logic [2:0]   op;
      logic [W-1:0] ra, rb;
      bit           seen;
      logic [W-1:0] corner [5];

      vecs[0]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0};
      vecs[1]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 1'b0};
      vecs[2]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b0, 1'b0};
      vecs[3]  = '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, 1'b0};
      vecs[4]  = '{3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b0};
      vecs[5]  = '{3'd5, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1};
      vecs[6]  = '{3'd7, 32'h00000007, 32'h00000000, 32'h00000007, 1'b0, 1'b1};
      vecs[7]  = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b0};
      vecs[8]  = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0};
      vecs[9]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0};
      vecs[10] = '{3'd0, 32'h00000003, 32'h00000005, 32'h0000000F, 1'b0, 1'b0};
      vecs[11] = '{3'd1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b0};
      vecs[12] = '{3'd4, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 1'b0};
      vecs[13] = '{3'd6, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0};
      vecs[14] = '{3'd6, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 1'b0, 1'b1};
      vecs[15] = '{3'd5, 32'h00000064, 32'h00000007, 32'h0000000E, 1'b0, 1'b0};

      corner[0] = 32'h00000000;
      corner[1] = 32'h00000001;
      corner[2] = 32'hFFFFFFFF;
      corner[3] = 32'h80000000;
      corner[4] = 32'h7FFFFFFF;

      $display("[TB] reset");
      #2 reset_n = 1'b0;
      #4;
      checkVal("rst_InReady", 64'(InReady), 64'd1);
      checkVal("rst_OutValid", 64'(OutValid), 64'd0);
      checkVal("rst_Result", 64'(Result), 64'd0);
      checkVal("rst_flags", 64'({N, Z, V, DZ}), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;

      $display("[TB] directed vectors");
      for (int i = 0; i < 16; i++) begin
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, lat);
         checkVal($sformatf("vec%0d_lat", i), 64'(lat), 64'(W + 1));
         checkOutput($sformatf("vec%0d", i), vecs[i].res, vecs[i].v, vecs[i].dz);
         releaseResult();
         checkVal($sformatf("vec%0d_idle", i), 64'({InReady, OutValid}), 64'b10);
      end

      $display("[TB] back-pressure");
      applyStimulus(3'd4, 32'hFFFFFFF9, 32'h00000002, lat);
      for (int k = 0; k < 10; k++) begin
         InValid   = 1'b1;
         MDControl = 3'($urandom_range(0, 7));
         A         = $urandom;
         B         = $urandom;
         @(negedge clk);
         checkVal($sformatf("bp%0d_res", k), 64'(Result), 64'hFFFFFFFD);
         checkVal($sformatf("bp%0d_hs", k), 64'({OutValid, InReady}), 64'b10);
         checkVal($sformatf("bp%0d_flags", k), 64'({N, Z, V, DZ}), 64'b1000);
      end
      InValid = 1'b0;
      releaseResult();
      checkVal("bp_release", 64'({InReady, OutValid}), 64'b10);

      $display("[TB] flush in CALC");
      startOp(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
      repeat (4) @(negedge clk);
      Flush = 1'b1;
      InValid = 1'b1;
      @(negedge clk);
      Flush = 1'b0;
      InValid = 1'b0;
      checkVal("flush_idle", 64'(InReady), 64'd1);
      seen = 1'b0;
      for (int k = 0; k < W + 5; k++) begin
         @(negedge clk);
         if (OutValid || !InReady) seen = 1'b1;
      end
      checkVal("flush_no_outvalid", 64'(seen), 64'd0);
      applyStimulus(3'd0, 32'd6, 32'd7, lat);
      checkOutput("after_flush", 32'd42, 1'b0, 1'b0);
      releaseResult();

      $display("[TB] reset in DONE and mid-CALC");
      applyStimulus(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
      #2 reset_n = 1'b0;
      #1;
      checkVal("rstdone_hs", 64'({InReady, OutValid}), 64'b10);
      checkVal("rstdone_res", 64'(Result), 64'd0);
      checkVal("rstdone_flags", 64'({N, Z, V, DZ}), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      startOp(3'd4, 32'd100, 32'd3);
      repeat (10) @(negedge clk);
      reset_n = 1'b0;
      #1;
      checkVal("rstcalc_ready", 64'(InReady), 64'd1);
      @(negedge clk);
      reset_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < W + 5; k++) begin
         @(negedge clk);
         if (OutValid || !InReady) seen = 1'b1;
      end
      checkVal("rst_no_residual", 64'(seen), 64'd0);

      $display("[TB] randomized ops");
      for (int i = 0; i < 60; i++) begin
         op = 3'($urandom_range(0, 7));
         ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 32'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 32'($urandom);
         refModel(op, ra, rb, eres, ev, edz);
         applyStimulus(op, ra, rb, lat);
         checkVal($sformatf("rnd%0d_lat", i), 64'(lat), 64'(W + 1));
         checkOutput($sformatf("rnd%0d_op%0d", i, op), eres, ev, edz);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         releaseResult();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of operands and result; legal range 4..64.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port Flush  input  1  synchronous abort of any in-flight operation.
REQ-005 SHALL have port InValid  input  1  operands and MDControl valid this cycle.
REQ-006 SHALL have port InReady  output  1  unit can accept a new operation.
REQ-007 SHALL have port MDControl  input  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 SHALL have port A  input  WIDTH  first operand (multiplicand/dividend).
REQ-009 SHALL have port B  input  WIDTH  second operand (multiplier/divisor).
REQ-010 SHALL have port Result  output  WIDTH  operation result.
REQ-011 SHALL have port OutValid  output  1  Result and flags valid.
REQ-012 SHALL have port OutReady  input  1  consumer accepts Result.
REQ-013 SHALL have ports N, Z, V, DZ  output  1 each  negative, zero, signed-division overflow, divide-by-zero flags.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE; InReady = (state == IDLE).
REQ-015 SHALL accept an operation on a rising edge with InValid & InReady, registering A, B, MDControl, and SHALL move IDLE -> CALC.
REQ-016 SHALL stay in CALC exactly WIDTH cycles, using a counter from WIDTH-1 down to 0, processing one bit per cycle (shift-add multiply, restoring divide on operand magnitudes).
REQ-017 SHALL move CALC -> DONE when the counter is 0; OutValid = (state == DONE); Result first visible WIDTH+1 cycles after the accept edge.
REQ-018 SHALL hold Result and flags stable in DONE until OutValid & OutReady, then move to IDLE; no new accept in the same cycle.
REQ-019 MUL SHALL return low WIDTH bits of the 2*WIDTH-bit product; MULH high bits of signed x signed; MULHSU high bits of signed A x unsigned B; MULHU high bits of unsigned x unsigned.
REQ-020 DIV/REM SHALL be signed, with quotient truncated toward zero and remainder taking the sign of A; DIVU/REMU SHALL be unsigned.
REQ-021 Divide by zero (B == 0, ops 1xx) SHALL give quotient all-ones and remainder = A, DZ = 1, same WIDTH+1 latency.
REQ-022 Signed overflow (DIV/REM, A = most-negative, B = -1) SHALL give quotient = A and remainder = 0, V = 1.
REQ-023 N SHALL equal Result[WIDTH-1] and Z SHALL equal (Result == 0), both qualified only while OutValid = 1.
REQ-024 DZ and V SHALL be 0 for all multiply ops.
REQ-025 Flush = 1 SHALL force state to IDLE on the next edge from any state, discarding results; Flush takes priority over accept and over OutReady.
REQ-026 InValid while InReady = 0 SHALL be ignored; upstream holds operands until accepted.

Reset
REQ-027 On reset_n low, the unit SHALL asynchronously enter IDLE with counter = 0, all internal registers 0, Result = 0, OutValid = 0, N = 0, Z = 0, V = 0, DZ = 0, InReady = 1.
REQ-028 Reset asserted mid-CALC or in DONE SHALL abort the operation with no residual output after deassertion.
REQ-029 After reset_n deasserts, the first accept SHALL occur no earlier than the first rising edge with reset_n high.

Verification (WIDTH = 32)
REQ-030 Test MULHU with A = 0xFFFFFFFF, B = 0xFFFFFFFF, OutReady = 1 -> Result = 0xFFFFFFFE, OutValid exactly 33 cycles after accept, N = 1, Z = 0.
REQ-031 Test MULH with A = 0x80000000, B = 0x80000000 -> Result = 0x40000000; then MUL with the same operands -> Result = 0x00000000, Z = 1.
REQ-032 Test signed DIV/REM with A = -7, B = 2 -> DIV = 0xFFFFFFFD (-3), REM = 0xFFFFFFFF (-1); then DIVU with A = 7, B = 0 -> Result = 0xFFFFFFFF, DZ = 1; REMU -> 7, DZ = 1.
REQ-033 Test signed overflow with DIV A = 0x80000000, B = 0xFFFFFFFF -> Result = 0x80000000, V = 1; REM with the same operands -> Result = 0, V = 1, Z = 1.
REQ-034 Test back-pressure with OutReady = 0 for 10 cycles in DONE -> Result, flags and OutValid stable, InReady = 0, InValid ignored; OutReady pulse -> IDLE next cycle.
REQ-035 Test aborts: Flush at CALC cycle 5 -> IDLE next edge, OutValid never asserts; reset_n low in DONE -> OutValid = 0 immediately (asynchronously), InReady = 1.
